// File: rtl/vslc_timer_bank.sv
// vslc_timer_bank: NUM_CH independent two-phase timers.
// Each channel has a power-of-two prescaler and three run modes: cycle, one-shot and gated.
// Channels are configured through a small write port and run under per-channel en/trig.
module vslc_timer_bank #(
  parameter int NUM_CH   = 4,
  parameter int WIDTH    = 16,
  parameter int DIV_BITS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_ch,
  input  logic [1:0]        cfg_addr,
  input  logic [WIDTH-1:0]  cfg_wdata,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] trig,
  output logic [NUM_CH-1:0] tmr_out,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done
);

  localparam int PW = (2**DIV_BITS) - 1;
  localparam logic [PW-1:0]    PRE_ONES = '1;
  localparam logic [PW-1:0]    PRE_ONE  = PW'(1);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [1:0]       MODE_ONESHOT = 2'd1;
  localparam logic [1:0]       MODE_GATED   = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN_A, ST_RUN_B, ST_HOLD} state_t;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t            state, nxt_state;
    logic [WIDTH-1:0]  prog_a, prog_b;
    logic [WIDTH-1:0]  act_a, act_b, nxt_act_a, nxt_act_b;
    logic [WIDTH-1:0]  cnt, nxt_cnt;
    logic [PW-1:0]     pre, nxt_pre, pre_max;
    logic [DIV_BITS-1:0] div_r;
    logic [1:0]        mode_r;
    logic              inv_r, nxt_inv;
    logic              held_a, nxt_held_a;
    logic              latch, nxt_latch;
    logic              done_r, nxt_done;
    logic              out_r, nxt_level;
    logic              hit, ctrl_wr, div_clr;
    logic              tick, in_a, running, do_start, end_b;

    assign hit     = cfg_we && (cfg_ch == 3'(i));
    assign ctrl_wr = hit && (cfg_addr == 2'd2);
    assign div_clr = ctrl_wr && (cfg_wdata[DIV_BITS-1:0] != div_r);
    assign nxt_inv = ctrl_wr ? cfg_wdata[DIV_BITS+2] : inv_r;
    assign pre_max = ~(PRE_ONES << div_r);
    assign tick    = (pre == pre_max);

    // Programmed periods and control fields; only the addressed channel changes.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prog_a <= WIDTH'(1);
        prog_b <= WIDTH'(2);
        div_r  <= '0;
        mode_r <= '0;
        inv_r  <= 1'b0;
      end else if (hit) begin
        case (cfg_addr)
          2'd0: prog_a <= cfg_wdata;
          2'd1: prog_b <= cfg_wdata;
          2'd2: begin
            div_r  <= cfg_wdata[DIV_BITS-1:0];
            mode_r <= cfg_wdata[DIV_BITS+1:DIV_BITS];
            inv_r  <= cfg_wdata[DIV_BITS+2];
          end
          default: ;
        endcase
      end
    end

    // Next-state, counter and prescaler logic; priority is en=0, then trig/start, then counting.
    // A HOLD channel that sees en=1 is processed as its saved phase for that edge, so the
    // paused edges are simply skipped and the phase keeps its full length.
    always_comb begin
      nxt_state  = state;
      nxt_cnt    = cnt;
      nxt_pre    = pre;
      nxt_act_a  = act_a;
      nxt_act_b  = act_b;
      nxt_held_a = held_a;
      nxt_latch  = latch;
      nxt_done   = 1'b0;
      do_start   = 1'b0;
      end_b      = 1'b0;
      in_a       = (state == ST_RUN_A) || ((state == ST_HOLD) && held_a);
      running    = (state != ST_IDLE);

      if (!en[i]) begin
        nxt_latch = 1'b0;
        if (running && (mode_r == MODE_GATED)) begin
          nxt_state  = ST_HOLD;
          nxt_held_a = in_a;
        end else begin
          nxt_state = ST_IDLE;
          nxt_cnt   = '0;
          nxt_pre   = '0;
        end
      end else if (trig[i] || ((state == ST_IDLE) && !latch)) begin
        do_start  = 1'b1;
        nxt_latch = 1'b0;
      end else if (running) begin
        if (tick) begin
          nxt_pre = '0;
          if (in_a) begin
            if (cnt == act_a - CNT_ONE) begin
              if (act_b != '0) begin
                nxt_state = ST_RUN_B;
                nxt_cnt   = '0;
              end else begin
                end_b = 1'b1;
              end
            end else begin
              nxt_state = ST_RUN_A;
              nxt_cnt   = cnt + CNT_ONE;
            end
          end else begin
            if (cnt == act_b - CNT_ONE) begin
              end_b = 1'b1;
            end else begin
              nxt_state = ST_RUN_B;
              nxt_cnt   = cnt + CNT_ONE;
            end
          end
        end else begin
          nxt_pre   = pre + PRE_ONE;
          nxt_state = in_a ? ST_RUN_A : ST_RUN_B;
        end

        if (end_b) begin
          nxt_done = 1'b1;
          if (mode_r == MODE_ONESHOT) begin
            nxt_state = ST_IDLE;
            nxt_latch = 1'b1;
            nxt_cnt   = '0;
            nxt_pre   = '0;
          end else begin
            do_start = 1'b1;
          end
        end
      end

      if (do_start) begin
        nxt_act_a  = prog_a;
        nxt_act_b  = prog_b;
        nxt_cnt    = '0;
        nxt_pre    = '0;
        nxt_held_a = 1'b0;
        if (prog_a != '0)      nxt_state = ST_RUN_A;
        else if (prog_b != '0) nxt_state = ST_RUN_B;
        else                   nxt_state = ST_IDLE;
      end

      nxt_level = (nxt_state == ST_RUN_A) || ((nxt_state == ST_HOLD) && nxt_held_a);
    end

    // Run state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state  <= ST_IDLE;
        cnt    <= '0;
        pre    <= '0;
        act_a  <= WIDTH'(1);
        act_b  <= WIDTH'(2);
        held_a <= 1'b0;
        latch  <= 1'b0;
        done_r <= 1'b0;
        out_r  <= 1'b0;
      end else begin
        state  <= nxt_state;
        cnt    <= nxt_cnt;
        pre    <= div_clr ? '0 : nxt_pre;
        act_a  <= nxt_act_a;
        act_b  <= nxt_act_b;
        held_a <= nxt_held_a;
        latch  <= nxt_latch;
        done_r <= nxt_done;
        out_r  <= nxt_level ^ nxt_inv;
      end
    end

    assign tmr_out[i] = out_r;
    assign busy[i]    = (state != ST_IDLE);
    assign done[i]    = done_r;
  end

endmodule

// File: tb/tb_vslc_timer_bank.sv
// Bench for vslc_timer_bank: table of per-cycle vectors, expectations queued on drive and
// compared one clock later, plus hand-written reset sequences.
module tb_vslc_timer_bank;
  localparam int NUM_CH   = 4;
  localparam int WIDTH    = 16;
  localparam int DIV_BITS = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_we;
  logic [2:0]        cfg_ch;
  logic [1:0]        cfg_addr;
  logic [WIDTH-1:0]  cfg_wdata;
  logic [NUM_CH-1:0] en, trig;
  logic [NUM_CH-1:0] tmr_out, busy, done;

  int checks   = 0;
  int failures = 0;

  vslc_timer_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DIV_BITS(DIV_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .en(en), .trig(trig), .tmr_out(tmr_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // exp packs {tmr_out[ch], busy[ch], done[ch]} expected after the edge that samples the vector
  typedef struct {
    string             name;
    logic              we;
    logic [2:0]        wch;
    logic [1:0]        waddr;
    logic [WIDTH-1:0]  wdata;
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] trig;
    int                ch;
    logic              chk;
    logic [2:0]        exp;
  } vec_t;

  typedef struct {
    string      name;
    int         idx;
    int         ch;
    logic [2:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];

  function automatic logic [WIDTH-1:0] ctrl(int dv, int md, int inv);
    logic [WIDTH-1:0] r;
    r = '0;
    r[DIV_BITS-1:0]  = dv[DIV_BITS-1:0];
    r[DIV_BITS+1 -: 2] = md[1:0];
    r[DIV_BITS+2]    = inv[0];
    return r;
  endfunction

  function automatic void addw(string name, int wch, int waddr, int wdata,
                               logic [NUM_CH-1:0] en_v, int ch, logic chk, logic [2:0] exp);
    vec_t v;
    v.name = name; v.we = 1'b1; v.wch = 3'(wch); v.waddr = 2'(waddr); v.wdata = WIDTH'(wdata);
    v.en = en_v; v.trig = '0; v.ch = ch; v.chk = chk; v.exp = exp;
    vecs.push_back(v);
  endfunction

  function automatic void add(string name, logic [NUM_CH-1:0] en_v, logic [NUM_CH-1:0] trig_v,
                              int ch, logic [2:0] exp);
    vec_t v;
    v.name = name; v.we = 1'b0; v.wch = '0; v.waddr = '0; v.wdata = '0;
    v.en = en_v; v.trig = trig_v; v.ch = ch; v.chk = 1'b1; v.exp = exp;
    vecs.push_back(v);
  endfunction

  function automatic void check(string name, int idx, logic [NUM_CH*3-1:0] act, logic [NUM_CH*3-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %b, expected %b", name, idx, act, exp);
    end
  endfunction

  task automatic apply_all();
    vec_t v;
    sb_t  e;
    sb_t  s;
    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      @(negedge clk);
      cfg_we = v.we; cfg_ch = v.wch; cfg_addr = v.waddr; cfg_wdata = v.wdata;
      en = v.en; trig = v.trig;
      if (v.chk) begin
        s.name = v.name; s.idx = k; s.ch = v.ch; s.exp = v.exp;
        sbq.push_back(s);
      end
      @(posedge clk);
      #1;
      cfg_we = 1'b0; trig = '0;
      if (v.chk) begin
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL scoreboard_empty[%0d]", k);
        end else begin
          e = sbq.pop_front();
          check(e.name, e.idx, 12'({tmr_out[e.ch], busy[e.ch], done[e.ch]}), 12'(e.exp));
        end
      end
    end
    vecs.delete();
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_wdata = '0;
    en = '0; trig = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", 0, 12'(tmr_out), 12'(0));
    check("rst_busy", 0, 12'(busy), 12'(0));
    check("rst_done", 0, 12'(done), 12'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // ch0: a=3 b=2 cycle -> 1,1,1,0,0 with done at each new high phase
    addw("s1_cfg", 0, 0, 3, 4'b0000, 0, 1'b1, 3'b000);
    addw("s1_cfg", 0, 1, 2, 4'b0000, 0, 1'b1, 3'b000);
    addw("s1_cfg", 0, 2, ctrl(0, 0, 0), 4'b0000, 0, 1'b1, 3'b000);
    for (int n = 0; n < 11; n++)
      add("s1_cycle", 4'b0001, 4'b0000, 0, {((n % 5) < 3), 1'b1, ((n > 0) && ((n % 5) == 0))});
    add("s1_stop", 4'b0000, 4'b0000, 0, 3'b000);
    apply_all();

    // ch1: div=2 one-shot a=1 b=1
    addw("s2_cfg", 1, 0, 1, 4'b0000, 1, 1'b1, 3'b000);
    addw("s2_cfg", 1, 1, 1, 4'b0000, 1, 1'b1, 3'b000);
    addw("s2_cfg", 1, 2, ctrl(2, 1, 0), 4'b0000, 1, 1'b1, 3'b000);
    for (int n = 0; n < 13; n++)
      add("s2_oneshot", 4'b0010, 4'b0000, 1,
          (n < 4) ? 3'b110 : (n < 8) ? 3'b010 : (n == 8) ? 3'b001 : 3'b000);
    add("s2_enlow", 4'b0000, 4'b0000, 1, 3'b000);
    for (int n = 0; n < 4; n++) add("s2_rerun", 4'b0010, 4'b0000, 1, 3'b110);
    add("s2_stop", 4'b0000, 4'b0000, 1, 3'b000);
    apply_all();

    // ch2: gated a=4 b=4, pause during phase A
    addw("s3_cfg", 2, 0, 4, 4'b0000, 2, 1'b1, 3'b000);
    addw("s3_cfg", 2, 1, 4, 4'b0000, 2, 1'b1, 3'b000);
    addw("s3_cfg", 2, 2, ctrl(0, 2, 0), 4'b0000, 2, 1'b1, 3'b000);
    add("s3_runa", 4'b0100, 4'b0000, 2, 3'b110);
    add("s3_runa", 4'b0100, 4'b0000, 2, 3'b110);
    for (int n = 0; n < 10; n++) add("s3_hold", 4'b0000, 4'b0000, 2, 3'b110);
    add("s3_resume", 4'b0100, 4'b0000, 2, 3'b110);
    add("s3_resume", 4'b0100, 4'b0000, 2, 3'b110);
    for (int n = 0; n < 4; n++) add("s3_runb", 4'b0100, 4'b0000, 2, 3'b010);
    add("s3_wrap", 4'b0100, 4'b0000, 2, 3'b111);
    add("s3_hold2", 4'b0000, 4'b0000, 2, 3'b110);
    addw("s3_modewr", 2, 2, ctrl(0, 0, 0), 4'b0000, 2, 1'b1, 3'b110);
    add("s3_toidle", 4'b0000, 4'b0000, 2, 3'b000);
    // same pause in cycle mode aborts to IDLE and restarts from scratch
    add("s3c_runa", 4'b0100, 4'b0000, 2, 3'b110);
    add("s3c_runa", 4'b0100, 4'b0000, 2, 3'b110);
    for (int n = 0; n < 3; n++) add("s3c_idle", 4'b0000, 4'b0000, 2, 3'b000);
    for (int n = 0; n < 4; n++) add("s3c_restart", 4'b0100, 4'b0000, 2, 3'b110);
    add("s3c_runb", 4'b0100, 4'b0000, 2, 3'b010);
    add("s3c_stop", 4'b0000, 4'b0000, 2, 3'b000);
    apply_all();

    // ch0: period_a=8 written in RUN_B; trig on the terminal B count
    for (int n = 0; n < 3; n++) add("s4_a3", 4'b0001, 4'b0000, 0, 3'b110);
    add("s4_b", 4'b0001, 4'b0000, 0, 3'b010);
    addw("s4_wr8", 0, 0, 8, 4'b0001, 0, 1'b1, 3'b010);
    add("s4_wrap", 4'b0001, 4'b0000, 0, 3'b111);
    for (int n = 0; n < 7; n++) add("s4_a8", 4'b0001, 4'b0000, 0, 3'b110);
    add("s4_b", 4'b0001, 4'b0000, 0, 3'b010);
    add("s4_b", 4'b0001, 4'b0000, 0, 3'b010);
    add("s4_trig", 4'b0001, 4'b0001, 0, 3'b110);
    for (int n = 0; n < 7; n++) add("s4_a8t", 4'b0001, 4'b0000, 0, 3'b110);
    add("s4_bt", 4'b0001, 4'b0000, 0, 3'b010);
    add("s4_stop", 4'b0000, 4'b0000, 0, 3'b000);
    apply_all();

    // ch3: invert on idle, out-of-range channel writes, default periods, both periods zero
    addw("s5_inv", 3, 2, ctrl(0, 0, 1), 4'b0000, 3, 1'b0, 3'b000);
    add("s5_inv", 4'b0000, 4'b0000, 3, 3'b100);
    addw("s5_ch7", 7, 0, 0, 4'b0000, 3, 1'b1, 3'b100);
    addw("s5_ch7", 7, 1, 0, 4'b0000, 3, 1'b1, 3'b100);
    addw("s5_ch7", 7, 2, ctrl(0, 0, 0), 4'b0000, 3, 1'b1, 3'b100);
    add("s5_ch7", 4'b0000, 4'b0000, 3, 3'b100);
    add("s5_def", 4'b1000, 4'b0000, 3, 3'b010);
    add("s5_def", 4'b1000, 4'b0000, 3, 3'b110);
    add("s5_def", 4'b1000, 4'b0000, 3, 3'b110);
    add("s5_def", 4'b1000, 4'b0000, 3, 3'b011);
    add("s5_stop", 4'b0000, 4'b0000, 3, 3'b100);
    addw("s5_zero", 3, 0, 0, 4'b0000, 3, 1'b1, 3'b100);
    addw("s5_zero", 3, 1, 0, 4'b0000, 3, 1'b1, 3'b100);
    for (int n = 0; n < 3; n++) add("s5_zero_en", 4'b1000, 4'b0000, 3, 3'b100);
    add("s5_zero_off", 4'b0000, 4'b0000, 3, 3'b100);
    // start ch0..ch2 together ahead of the reset test
    add("s6_run", 4'b0111, 4'b0000, 2, 3'b110);
    add("s6_run", 4'b0111, 4'b0000, 2, 3'b110);
    apply_all();

    // asynchronous reset in mid-phase
    check("s6_busy_pre", 0, 12'(busy), 12'(4'b0111));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_rst_out", 0, 12'(tmr_out), 12'(0));
    check("s6_rst_busy", 0, 12'(busy), 12'(0));
    check("s6_rst_done", 0, 12'(done), 12'(0));
    en = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // defaults after reset: invert cleared, periods 1/2
    add("s6_inv_def", 4'b0000, 4'b0000, 3, 3'b000);
    add("s6_def", 4'b0001, 4'b0000, 0, 3'b110);
    add("s6_def", 4'b0001, 4'b0000, 0, 3'b010);
    add("s6_def", 4'b0001, 4'b0000, 0, 3'b010);
    add("s6_def", 4'b0001, 4'b0000, 0, 3'b111);
    add("s6_def", 4'b0001, 4'b0000, 0, 3'b010);
    add("s6_stop", 4'b0000, 4'b0000, 0, 3'b000);
    apply_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
